// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter sharing the single register-file write
//                port between two requesters. Fully registered write command
//                (we/wAddr/wData) and a one-cycle ack pulse per write. At most
//                one write every two clocks (IDLE -> WRITE -> IDLE).
//  Options     : ARB_CONFLICT_CNT_EN - when defined, builds a saturating
//                8-bit counter of IDLE cycles seeing both requests; when
//                undefined, conflict_cnt is tied to 8'h00.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0] wData,
    output logic [7:0]            conflict_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_we;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_any_req;
    logic                  w_grant1;

    // Requester 1 wins when alone, or on a conflict when requester 0 was
    // served last (last_grant == 0).
    assign w_any_req = req0 | req1;
    assign w_grant1  = req1 & (~req0 | ~r_last_grant);

    // Arbitration FSM: IDLE samples requests, WRITE is the single-cycle
    // write/ack slot. Requests are ignored in WRITE so a requester dropping
    // req on the ack-ending edge never causes a duplicate write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_WRITE;
                        r_we         <= 1'b1;
                        r_ack0       <= ~w_grant1;
                        r_ack1       <= w_grant1;
                        r_waddr      <= w_grant1 ? addr1 : addr0;
                        r_wdata      <= w_grant1 ? data1 : data0;
                        r_last_grant <= w_grant1;
                    end else begin
                        r_we   <= 1'b0;
                        r_ack0 <= 1'b0;
                        r_ack1 <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // wAddr/wData hold; they are don't-care while we is low.
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                end
            endcase
        end
    end

    assign we    = r_we;
    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign wAddr = r_waddr;
    assign wData = r_wdata;

`ifdef ARB_CONFLICT_CNT_EN
    localparam logic [7:0] c_CNT_SAT = 8'hFF;

    logic [7:0] r_conflict_cnt;

    // Count IDLE edges where both requesters compete; saturate at the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= 8'h00;
        end else if ((r_state == ST_IDLE) && req0 && req1 &&
                     (r_conflict_cnt != c_CNT_SAT)) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Self-checking bench for reg_write_arbiter. Expected writes
//                are queued when requests are driven and popped by a monitor
//                whenever the write port fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;

`ifdef ARB_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic          who;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          ack0;
    logic          ack1;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
    logic [7:0]    conflict_cnt;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req0),
        .addr0        (addr0),
        .data0        (data0),
        .req1         (req1),
        .addr1        (addr1),
        .data1        (data1),
        .ack0         (ack0),
        .ack1         (ack1),
        .we           (we),
        .wAddr        (wAddr),
        .wData        (wData),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checks++;
            if ((ack0 === 1'b1 && ack1 === 1'b1) || ((ack0 | ack1) !== we)) begin
                errors++;
                $display("FAIL ack_vs_we t=%0t: we=%b ack0=%b ack1=%b, need exactly one ack with we",
                         $time, we, ack0, ack1);
            end
            if (we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write t=%0t: wAddr=%0d wData=%h, none expected",
                             $time, wAddr, wData);
                end else begin
                    mon_e = sb.pop_front();
                    if (wAddr !== mon_e.addr || wData !== mon_e.data ||
                        ack0 !== ~mon_e.who || ack1 !== mon_e.who) begin
                        errors++;
                        $display("FAIL write_cmd t=%0t: got addr=%0d data=%h ack0=%b ack1=%b, need addr=%0d data=%h grant=%0d",
                                 $time, wAddr, wData, ack0, ack1, mon_e.addr, mon_e.data, mon_e.who);
                    end
                end
            end
        end
    end

    // Bounded wait for the next write pulse; returns cycles taken.
    task automatic wait_we(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (we === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_we_timeout t=%0t: no write within 6 cycles", $time);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Holds both requests for n writes; grants must alternate from 'first'
    // with one write every second cycle.
    task automatic run_both(input int n, input bit first);
        int cyc;
        bit ok;
        bit g;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < n; i++) begin
            g = first ^ i[0];
            sb.push_back('{who: g, addr: (g ? addr1 : addr0), data: (g ? data1 : data0)});
            wait_we(cyc, ok);
            if (!ok) break;
            checks++;
            if (cyc != ((i == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL rr_spacing write %0d: got %0d cycles, need %0d",
                         i, cyc, (i == 0) ? 1 : 2);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || wAddr !== '0 ||
            wData !== '0 || conflict_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: we=%b ack0=%b ack1=%b wAddr=%0d wData=%h cnt=%h, need all zero",
                     we, ack0, ack1, wAddr, wData, conflict_cnt);
        end
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        addr0 = 3'd5;
        data0 = 32'hDEADBEEF;
        sb.push_back('{who: 1'b0, addr: 3'd5, data: 32'hDEADBEEF});
        req0 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (we !== 1'b1 || ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: we=%b ack0=%b ack1=%b, need 1 1 0", we, ack0, ack1);
        end
        req0 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (we !== 1'b0 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: we=%b ack0=%b, need 0 0", we, ack0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        addr0 = 3'd1; data0 = 32'h0A0A0A0A;
        addr1 = 3'd2; data1 = 32'h1B1B1B1B;
        run_both(8, 1'b0);
        checks++;
        if (conflict_cnt !== (CNT_EN ? 8'd8 : 8'd0)) begin
            errors++;
            $display("FAIL conflict_cnt_8: got %0d, need %0d", conflict_cnt, CNT_EN ? 8 : 0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin_update();
        int cyc;
        bit ok;
        // last grant was requester 1; singles must still go through directly
        addr1 = 3'd7; data1 = 32'h00000001;
        sb.push_back('{who: 1'b1, addr: 3'd7, data: 32'h00000001});
        req1 = 1'b1;
        wait_we(cyc, ok);
        req1 = 1'b0;
        addr0 = 3'd4; data0 = 32'h44444444;
        sb.push_back('{who: 1'b0, addr: 3'd4, data: 32'h44444444});
        req0 = 1'b1;
        wait_we(cyc, ok);
        req0 = 1'b0;
        // last grant now 0 -> next conflict must favour requester 1
        @(posedge clk);
        #1;
        run_both(2, 1'b1);
        // last grant 0 again; a single from 1 flips it, conflict favours 0
        @(posedge clk);
        #1;
        addr1 = 3'd6; data1 = 32'h66666666;
        sb.push_back('{who: 1'b1, addr: 3'd6, data: 32'h66666666});
        req1 = 1'b1;
        wait_we(cyc, ok);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        run_both(1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        bit ok;
        addr1 = 3'd7; data1 = 32'h00000001;
        req1 = 1'b1;
        wait_we(cyc, ok);
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_ack1: got %b, need 1", ack1);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || wAddr !== '0 || wData !== '0) begin
            errors++;
            $display("FAIL midreset_async_clear: we=%b ack0=%b ack1=%b wAddr=%0d wData=%h, need all zero",
                     we, ack0, ack1, wAddr, wData);
        end
        req1 = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (we !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_write cycle %0d: we=%b, need 0", i, we);
            end
        end
        sb.push_back('{who: 1'b1, addr: 3'd7, data: 32'h00000001});
        req1 = 1'b1;
        wait_we(cyc, ok);
        req1 = 1'b0;
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL midreset_rerequest_latency: got %0d cycles, need 1", cyc);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_conflict_cnt();
        apply_reset();
        addr0 = 3'd3; data0 = 32'hA5A5A5A5;
        addr1 = 3'd0; data1 = 32'h5A5A5A5A;
        run_both(300, 1'b0);
        checks++;
        if (conflict_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            errors++;
            $display("FAIL conflict_cnt_saturate: got %h, need %h",
                     conflict_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_round_robin_update();
        test_reset_mid_write();
        test_conflict_cnt();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, need 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
